seq_controller: RTL and testbench
=================================

SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter: SHOW_CYCLES, 4, clock cycles each sequence LED is lit during playback.
REQ-002 Parameter: GAP_CYCLES, 2, clock cycles LEDs are dark between playback steps.
REQ-003 Parameter: TIMEOUT_CYCLES, 64, idle cycles allowed between player presses before loss.
REQ-004 Port: clock  input  1  single system clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  single-cycle pulse; begins a new game from IDLE, WIN or LOSE.
REQ-007 Port: botoes  input  4  player buttons, debounced, one-cycle pulse per press.
REQ-008 Port: saida  input  4  one-hot step value from the sequence ROM for the current address (combinational, same cycle).
REQ-009 Port: address  output  4  registered step index driven to the sequence ROM.
REQ-010 Port: leds  output  4  registered LED drive.
REQ-011 Port: nivel  output  5  current round length, 1..16.
REQ-012 Port: busy  output  1  high in every state except IDLE, WIN, LOSE.
REQ-013 Port: win  output  1  high only in WIN.
REQ-014 Port: lose  output  1  high only in LOSE.

Function
REQ-015 FSM states: IDLE, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, LOSE.
REQ-016 IDLE/WIN/LOSE + start: nivel<=1, address<=0, timer<=0, next SHOW_ON.
REQ-017 SHOW_ON: leds<=saida; after SHOW_CYCLES cycles -> SHOW_GAP, timer cleared.
REQ-018 SHOW_GAP: leds=0; after GAP_CYCLES cycles: if address==nivel-1 then address<=0, -> WAIT_IN; else address<=address+1, -> SHOW_ON.
REQ-019 WAIT_IN: leds mirror botoes registered one cycle (press echo); timer counts up each cycle with botoes==0.
REQ-020 WAIT_IN press (botoes!=0): match iff botoes==saida exactly; any multi-bit or wrong vector -> LOSE.
REQ-021 Match with address<nivel-1: address<=address+1, timer<=0, stay WAIT_IN.
REQ-022 Match with address==nivel-1 and nivel<16: nivel<=nivel+1, address<=0, -> SHOW_GAP then SHOW_ON (gap precedes replay; GAP step with address wrap rule bypassed).
REQ-023 Match with address==nivel-1 and nivel==16: -> WIN.
REQ-024 Timer reaching TIMEOUT_CYCLES-1 in WAIT_IN with no press -> LOSE; a press on that same cycle takes priority over timeout.
REQ-025 botoes ignored in every state except WAIT_IN; start ignored while busy=1.
REQ-026 WIN: leds=4'b1111; LOSE: leds=4'b0000; both hold until start or reset.
REQ-027 address never exceeds nivel-1; nivel never exceeds 16; no wrap of either.
REQ-028 Outputs busy/win/lose decoded from registered state only (glitch-free).

Reset
REQ-029 On reset low, asynchronously: state=IDLE, address=0, leds=0, nivel=1, timer=0, busy=0, win=0, lose=0.
REQ-030 Reset asserted mid-playback or mid-input aborts immediately; no press or start is honoured until reset releases.
REQ-031 First state change after reset release requires a start pulse.

Verification
REQ-032 Reset, start, SHOW_CYCLES=4, ROM step0=0001 -> address=0, leds=0001 for 4 cycles, then 0000 for 2 cycles, then WAIT_IN, busy=1, nivel=1.
REQ-033 Round 1, press 0001 -> nivel=2, replay shows step0=0001 then step1=1000, then WAIT_IN with address=0.
REQ-034 Round 2, press 0001 then 0100 (expected 1000) -> lose=1, busy=0, leds=0000; start -> nivel=1, SHOW_ON.
REQ-035 WAIT_IN, no press for TIMEOUT_CYCLES=64 -> lose=1 on cycle 64; press on cycle 64 -> accepted instead.
REQ-036 Press 0011 in WAIT_IN -> LOSE; 16 rounds all correct -> win=1, leds=1111, nivel=16.
REQ-037 Assert reset during SHOW_ON of round 3 -> all outputs zero, nivel=1, state IDLE same cycle, botoes pulses ignored.

Source files
------------

// File: rtl/seq_controller.sv
// Memory-game sequencer: replays a ROM sequence on the LEDs, then checks the
// player's button presses step by step, growing the round up to 16 steps.
module seq_controller #(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] botoes,
    input  logic [3:0] saida,
    output logic [3:0] address,
    output logic [3:0] leds,
    output logic [4:0] nivel,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int TMAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_address;
    logic [3:0]      r_leds;
    logic [4:0]      r_nivel;
    logic [TW-1:0]   r_timer;
    logic            r_replay;

    logic            w_last_step;
    logic            w_press;
    logic            w_match;
    logic            w_full;

    assign w_last_step = ({1'b0, r_address} == (r_nivel - 5'd1));
    assign w_press     = |botoes;
    assign w_match     = (botoes == saida);
    assign w_full      = (r_nivel == 5'd16);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_address <= '0;
            r_leds    <= '0;
            r_nivel   <= 5'd1;
            r_timer   <= '0;
            r_replay  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        r_state   <= S_SHOW_ON;
                        r_nivel   <= 5'd1;
                        r_address <= '0;
                        r_timer   <= '0;
                        r_leds    <= '0;
                        r_replay  <= 1'b0;
                    end
                end
                S_SHOW_ON: begin
                    r_leds <= saida;
                    if (r_timer == SHOW_LAST) begin
                        r_timer <= '0;
                        r_state <= S_SHOW_GAP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SHOW_GAP: begin
                    r_leds <= '0;
                    if (r_timer == GAP_LAST) begin
                        r_timer <= '0;
                        // A gap entered after a completed round restarts playback at step 0
                        if (r_replay) begin
                            r_replay <= 1'b0;
                            r_state  <= S_SHOW_ON;
                        end else if (w_last_step) begin
                            r_address <= '0;
                            r_state   <= S_WAIT_IN;
                        end else begin
                            r_address <= r_address + 4'd1;
                            r_state   <= S_SHOW_ON;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    r_leds <= botoes;
                    if (w_press) begin
                        r_timer <= '0;
                        if (!w_match) begin
                            r_leds  <= '0;
                            r_state <= S_LOSE;
                        end else if (!w_last_step) begin
                            r_address <= r_address + 4'd1;
                        end else if (w_full) begin
                            r_leds  <= 4'b1111;
                            r_state <= S_WIN;
                        end else begin
                            r_nivel   <= r_nivel + 5'd1;
                            r_address <= '0;
                            r_replay  <= 1'b1;
                            r_state   <= S_SHOW_GAP;
                        end
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_timer <= '0;
                        r_leds  <= '0;
                        r_state <= S_LOSE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address = r_address;
    assign leds    = r_leds;
    assign nivel   = r_nivel;
    assign busy    = (r_state == S_SHOW_ON) || (r_state == S_SHOW_GAP) || (r_state == S_WAIT_IN);
    assign win     = (r_state == S_WIN);
    assign lose    = (r_state == S_LOSE);

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: a ROM array in the bench feeds saida, and the
// expected LED/step trace is derived from the round length and ROM contents.
module tb_seq_controller;

    localparam int SHOW    = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] botoes;
    logic [3:0] saida;
    logic [3:0] address;
    logic [3:0] leds;
    logic [4:0] nivel;
    logic       busy;
    logic       win;
    logic       lose;

    logic [3:0] rom [16];

    int total = 0;
    int bad   = 0;

    assign saida = rom[address];

    seq_controller #(
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .botoes  (botoes),
        .saida   (saida),
        .address (address),
        .leds    (leds),
        .nivel   (nivel),
        .busy    (busy),
        .win     (win),
        .lose    (lose)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < 16; i++) rom[i] = 4'(4'b0001 << $urandom_range(0, 3));
    endtask

    // Playback of an n-step round: each step is SHOW lit cycles then GAP dark
    // cycles; buttons and start are noise here and must be ignored.
    task automatic play(input int n);
        for (int j = 0; j < n; j++) begin
            for (int k = 1; k <= SHOW + GAP; k++) begin
                start  = 1'($urandom_range(0, 1));
                botoes = 4'($urandom_range(0, 15));
                step();
                chk("play_leds", leds, (k <= SHOW) ? rom[j] : 4'b0000);
                chk("play_busy", busy, 1);
                if (k == 1) chk("play_addr", address, j);
            end
        end
        start  = 1'b0;
        botoes = 4'b0000;
        chk("wait_addr", address, 0);
        chk("wait_nivel", nivel, n);
        chk("wait_busy", busy, 1);
    endtask

    task automatic idle_wait(input int c);
        for (int i = 0; i < c; i++) begin
            botoes = 4'b0000;
            step();
            chk("idle_leds", leds, 0);
            chk("idle_busy", busy, 1);
        end
    endtask

    task automatic begin_game();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_nivel", nivel, 1);
        chk("start_addr", address, 0);
        chk("start_leds", leds, 0);
        chk("start_winlose", {win, lose}, 0);
        play(1);
    endtask

    task automatic run_round(input int n, input bit replay, input int first_idle);
        int idle;
        for (int j = 0; j < n; j++) begin
            idle = (j == 0 && first_idle >= 0) ? first_idle : int'($urandom_range(0, 3));
            idle_wait(idle);
            botoes = rom[j];
            step();
            botoes = 4'b0000;
            if (j < n - 1) begin
                chk("echo_leds", leds, rom[j]);
                chk("next_addr", address, j + 1);
                chk("press_busy", busy, 1);
            end else if (n < 16) begin
                chk("echo_leds", leds, rom[j]);
                chk("grow_nivel", nivel, n + 1);
                chk("grow_addr", address, 0);
                step();
                chk("gap1_leds", leds, 0);
                chk("gap1_busy", busy, 1);
                step();
                chk("gap2_leds", leds, 0);
                if (replay) play(n + 1);
            end else begin
                chk("win_flag", win, 1);
                chk("win_lose", lose, 0);
                chk("win_busy", busy, 0);
                chk("win_leds", leds, 4'b1111);
                chk("win_nivel", nivel, 16);
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        botoes = 4'b0000;
        randomize_rom();

        // held in reset: nothing is honoured
        for (int i = 0; i < 3; i++) begin
            start  = 1'b1;
            botoes = 4'($urandom_range(1, 15));
            step();
            chk("rst_busy", busy, 0);
            chk("rst_leds", leds, 0);
            chk("rst_nivel", nivel, 1);
            chk("rst_addr", address, 0);
            chk("rst_winlose", {win, lose}, 0);
        end
        start  = 1'b0;
        botoes = 4'b0000;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            botoes = 4'($urandom_range(1, 15));
            step();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_leds", leds, 0);
        end
        botoes = 4'b0000;

        // directed two-step game: right press, then a wrong one
        rom[0] = 4'b0001;
        rom[1] = 4'b1000;
        begin_game();
        run_round(1, 1'b1, -1);
        idle_wait($urandom_range(0, 3));
        botoes = 4'b0001;
        step();
        chk("g1_echo", leds, 4'b0001);
        chk("g1_addr", address, 1);
        botoes = 4'b0100;
        step();
        botoes = 4'b0000;
        chk("wrong_lose", lose, 1);
        chk("wrong_busy", busy, 0);
        chk("wrong_leds", leds, 0);
        for (int i = 0; i < 3; i++) begin
            botoes = 4'($urandom_range(1, 15));
            step();
            chk("lose_hold", lose, 1);
            chk("lose_leds", leds, 0);
        end
        botoes = 4'b0000;
        begin_game();

        // timeout on the 64th idle cycle
        idle_wait(TIMEOUT - 1);
        step();
        chk("timeout_lose", lose, 1);
        chk("timeout_busy", busy, 0);

        // press on the 64th cycle wins over timeout, then a multi-bit press loses
        randomize_rom();
        begin_game();
        run_round(1, 1'b1, TIMEOUT - 1);
        botoes = 4'b0011;
        step();
        botoes = 4'b0000;
        chk("multi_lose", lose, 1);
        chk("multi_leds", leds, 0);

        // full game to 16 steps
        randomize_rom();
        begin_game();
        for (int n = 1; n <= 16; n++) run_round(n, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            botoes = 4'($urandom_range(1, 15));
            step();
            chk("win_hold", win, 1);
            chk("win_hold_leds", leds, 4'b1111);
        end
        botoes = 4'b0000;

        // asynchronous reset during round 3 playback
        randomize_rom();
        begin_game();
        run_round(1, 1'b1, -1);
        run_round(2, 1'b0, -1);
        step();
        step();
        chk("r3_leds", leds, rom[0]);
        #3 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_leds", leds, 0);
        chk("arst_nivel", nivel, 1);
        chk("arst_addr", address, 0);
        chk("arst_winlose", {win, lose}, 0);
        for (int i = 0; i < 3; i++) begin
            start  = 1'b1;
            botoes = 4'($urandom_range(1, 15));
            step();
            chk("arst_hold_busy", busy, 0);
            chk("arst_hold_leds", leds, 0);
            chk("arst_hold_nivel", nivel, 1);
        end
        start  = 1'b0;
        botoes = 4'b0000;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rel_busy", busy, 0);
            chk("rel_nivel", nivel, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
